// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-address type and the pipeline controller
// state encoding, plus the bundle of per-cycle pipeline control strobes.
package cpu_types_pkg;

    localparam int REGADDR_W = 5;

    typedef logic [REGADDR_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMDONE = 2'b01,
        HALTED  = 2'b10
    } ctrl_state_t;

    // One cycle's worth of pipeline register controls.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
        logic exmem_clearMemReq;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the datapath (master) and the pipeline
// controller (slave): hazard/cache status in, register controls out.
interface pipeline_controller_if #(
    parameter int REGADDR_W = 5
);
    logic                 ihit;
    logic                 dhit;
    logic                 mem_dREN;
    logic                 mem_dWEN;
    logic                 ex_dREN;
    logic [REGADDR_W-1:0] ex_wsel;
    logic [REGADDR_W-1:0] id_rs;
    logic [REGADDR_W-1:0] id_rt;
    logic                 ex_branch_taken;
    logic                 id_jump;
    logic                 wb_halt;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic exmem_clearMemReq;
    logic halt;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               ex_branch_taken, id_jump, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               exmem_clearMemReq, halt
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               ex_branch_taken, id_jump, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               exmem_clearMemReq, halt
    );
endinterface

// File: rtl/pipeline_controller_hazard_unit.sv
// Load-use hazard detector: the instruction in ID needs a register that
// the load currently in EX has not yet fetched. Register 0 never hazards.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int REGADDR_W = 5
) (
    input  logic                 ex_dREN,
    input  logic [REGADDR_W-1:0] ex_wsel,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    output logic                 lu_stall
);

    // Pure compare; the controller decides whether the stall is honoured.
    always_comb begin
        lu_stall = ex_dREN && (ex_wsel != '0) &&
                   ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline controller: generates PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables and
// flushes from cache handshakes, hazards, branches/jumps and halt.
// Optional build macro PIPELINE_CONTROLLER_PERF_EN adds saturating
// stall_cycles / flush_count performance counters.
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int REGADDR_W = 5
`ifdef PIPELINE_CONTROLLER_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_controller_if.slave bus
`ifdef PIPELINE_CONTROLLER_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
`endif
);

    ctrl_state_t state_q, state_d;
    logic        halt_q, halt_d;
    ctrl_out_t   ctrl;
    logic        lu_stall;
    logic        mem_req;
    logic        advance;

    hazard_unit #(
        .REGADDR_W (REGADDR_W)
    ) u_hazard (
        .ex_dREN  (bus.ex_dREN),
        .ex_wsel  (bus.ex_wsel),
        .id_rs    (bus.id_rs),
        .id_rt    (bus.id_rt),
        .lu_stall (lu_stall)
    );

    // Next state and per-cycle controls from current state plus inputs.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        advance = 1'b0;
        // After the data access completes the request is already dropped
        // in EX/MEM, so it no longer gates progress in MEMDONE.
        mem_req = (state_q == RUN) && (bus.mem_dREN || bus.mem_dWEN);

        case (state_q)
            RUN: begin
                advance = bus.ihit && (!mem_req || bus.dhit);
                if (mem_req && bus.dhit && !bus.ihit) begin
                    ctrl.exmem_clearMemReq = 1'b1;
                    state_d                = MEMDONE;
                end
            end
            MEMDONE: begin
                advance = bus.ihit;
                if (bus.ihit) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                ctrl.exmem_flush = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // A halt reaching WB freezes the pipe right away; a clearMemReq
        // already decided for this cycle is left intact.
        if (bus.wb_halt) begin
            state_d = HALTED;
            advance = 1'b0;
        end

        if (advance) begin
            ctrl.pc_en    = 1'b1;
            ctrl.ifid_en  = 1'b1;
            ctrl.idex_en  = 1'b1;
            ctrl.exmem_en = 1'b1;
            ctrl.memwb_en = 1'b1;
            // Branch wins outright: the wrong-path fetch and ID are both
            // squashed and the PC takes the target.
            if (bus.ex_branch_taken) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (lu_stall) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX. A jump in
                // ID is seen again on the next advance.
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_en    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end else if (bus.id_jump) begin
                ctrl.ifid_flush = 1'b1;
            end
        end

        // Controls stay quiet while reset is held.
        if (!nRST) begin
            ctrl = '0;
        end

        halt_d = (state_d == HALTED);
    end

    // State and sticky halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.pc_en             = ctrl.pc_en;
    assign bus.ifid_en           = ctrl.ifid_en;
    assign bus.idex_en           = ctrl.idex_en;
    assign bus.exmem_en          = ctrl.exmem_en;
    assign bus.memwb_en          = ctrl.memwb_en;
    assign bus.ifid_flush        = ctrl.ifid_flush;
    assign bus.idex_flush        = ctrl.idex_flush;
    assign bus.exmem_flush       = ctrl.exmem_flush;
    assign bus.memwb_flush       = ctrl.memwb_flush;
    assign bus.exmem_clearMemReq = ctrl.exmem_clearMemReq;
    assign bus.halt              = halt_q;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Saturating counters of PC-hold cycles and front-end flush cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((state_q != HALTED) && !ctrl.pc_en && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if ((ctrl.ifid_flush || ctrl.idex_flush) && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed steps from the
// test plan followed by randomized traffic, checked every cycle against a
// rule-level reference model.
module tb_pipeline_controller;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;

    pipeline_controller_if #(.REGADDR_W(5)) bus ();

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [31:0] stall_cycles, flush_count;
    pipeline_controller #(.REGADDR_W(5), .CNT_W(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .bus          (bus),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    pipeline_controller #(.REGADDR_W(5)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );
`endif

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state: sticky halt, and "data done, waiting for ihit".
    bit          m_halted  = 1'b0;
    bit          m_memdone = 1'b0;
    logic [31:0] m_stall   = '0;
    logic [31:0] m_flush   = '0;

    // Bit order: pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_f, idex_f,
    // exmem_f, memwb_f, clearMemReq, halt
    function automatic logic [10:0] observed();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.exmem_clearMemReq, bus.halt};
    endfunction

    function automatic logic [10:0] model_out();
        logic [10:0] o;
        bit req, adv, lu;
        o = '0;
        if (!nRST) return o;
        if (m_halted) begin
            o[3] = 1'b1; o[2] = 1'b1; o[0] = 1'b1;
            return o;
        end
        req  = !m_memdone && (bus.mem_dREN || bus.mem_dWEN);
        o[1] = req && bus.dhit && !bus.ihit;
        if (bus.wb_halt) return o;
        adv = bus.ihit && (!req || bus.dhit);
        if (!adv) return o;
        o[10:6] = 5'b11111;
        lu = bus.ex_dREN && (bus.ex_wsel != 0) &&
             (bus.ex_wsel == bus.id_rs || bus.ex_wsel == bus.id_rt);
        if (bus.ex_branch_taken) begin
            o[5] = 1'b1; o[4] = 1'b1;
        end else if (lu) begin
            o[10] = 1'b0; o[9] = 1'b0; o[4] = 1'b1;
        end else if (bus.id_jump) begin
            o[5] = 1'b1;
        end
        return o;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_halted)  return HALTED;
        if (m_memdone) return MEMDONE;
        return RUN;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".outs"}, {21'd0, observed()}, {21'd0, model_out()});
        check({tag, ".state"}, {30'd0, dut.state_q}, {30'd0, model_state()});
`ifdef PIPELINE_CONTROLLER_PERF_EN
        check({tag, ".stall_cnt"}, stall_cycles, m_stall);
        check({tag, ".flush_cnt"}, flush_count, m_flush);
`endif
    endtask

    // One clock: check at negedge, advance model with DUT at posedge.
    task automatic cycle(input string tag);
        logic [10:0] e;
        @(negedge CLK);
        check_all(tag);
        e = model_out();
        @(posedge CLK);
        if (nRST) begin
            if (!m_halted && !e[10] && m_stall != '1) m_stall++;
            if ((e[5] || e[4]) && m_flush != '1) m_flush++;
            if (m_halted || bus.wb_halt) m_halted = 1'b1;
            else if (e[1])               m_memdone = 1'b1;
            else if (m_memdone && bus.ihit) m_memdone = 1'b0;
        end
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic reset_pulse(input string tag);
        @(negedge CLK);
        #1 nRST = 1'b0;
        m_halted = 1'b0; m_memdone = 1'b0; m_stall = '0; m_flush = '0;
        #1 check_all(tag);
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.ihit = 0; bus.dhit = 0; bus.mem_dREN = 0; bus.mem_dWEN = 0;
        bus.ex_dREN = 0; bus.ex_wsel = 0; bus.id_rs = 0; bus.id_rt = 0;
        bus.ex_branch_taken = 0; bus.id_jump = 0; bus.wb_halt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        idle_inputs();
        cycle("reset0");
        cycle("reset1");
        nRST = 1'b1;

        // Free-running fetch, no hazards.
        bus.ihit = 1;
        for (int i = 0; i < 10; i++) cycle($sformatf("run%0d", i));

        // Load miss: 3 stalls, dhit without ihit, MEMDONE wait, then advance.
        bus.ihit = 0; bus.mem_dREN = 1;
        for (int i = 0; i < 3; i++) cycle($sformatf("dmiss%0d", i));
        bus.dhit = 1;
        cycle("dhit_clear");
        bus.dhit = 0; bus.mem_dREN = 0;
        cycle("memdone_wait");
        bus.ihit = 1;
        cycle("memdone_adv");
        cycle("back_run");

        // Load-use on rt, then same with destination r0.
        bus.ex_dREN = 1; bus.ex_wsel = 5'd8; bus.id_rt = 5'd8;
        cycle("loaduse");
        bus.ex_wsel = 5'd0; bus.id_rt = 5'd0;
        cycle("loaduse_r0");

        // Branch beats load-use; nothing happens without ihit.
        bus.ex_wsel = 5'd8; bus.id_rt = 5'd8; bus.ex_branch_taken = 1;
        cycle("branch_lu");
        bus.ihit = 0;
        cycle("branch_stall");
        bus.ihit = 1; bus.ex_branch_taken = 0; bus.id_jump = 1;
        cycle("jump_lu");
        bus.ex_dREN = 0;
        cycle("jump_only");
        bus.id_jump = 0;

        // Halt: absorbing for 20 cycles, then reset.
        bus.wb_halt = 1;
        cycle("halt_req");
        bus.wb_halt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.ihit = 1'($urandom); bus.mem_dWEN = 1'($urandom);
            cycle($sformatf("halted%0d", i));
        end
        reset_pulse("halt_reset");
        idle_inputs();
        cycle("post_reset");

        // Randomized traffic with occasional halts and mid-stall resets.
        for (int i = 0; i < 600; i++) begin
            bus.ihit            = ($urandom_range(0, 3) != 0);
            bus.dhit            = 1'($urandom);
            bus.mem_dREN        = ($urandom_range(0, 3) == 0);
            bus.mem_dWEN        = ($urandom_range(0, 5) == 0);
            bus.ex_dREN         = 1'($urandom);
            bus.ex_wsel         = 5'($urandom_range(0, 3));
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
            bus.id_jump         = ($urandom_range(0, 4) == 0);
            bus.wb_halt         = ($urandom_range(0, 60) == 0);
            cycle($sformatf("rnd%0d", i));
            if (m_halted && $urandom_range(0, 4) == 0) reset_pulse($sformatf("rnd_rst%0d", i));
            else if (!m_halted && $urandom_range(0, 80) == 0) reset_pulse($sformatf("rnd_srst%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) by generating their enable, flush and clearMemReq controls.
- Inputs it arbitrates: cache handshakes (ihit/dhit), load-use hazards, taken branches/jumps and halt.
- Sits beside the datapath in the CPU top level; owns the PC write enable and the sticky halt.

Parameters:
REGADDR_W, 5, register-address width for hazard compares
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous reset, active-low
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
mem_dREN  in  1  EX/MEM register read request
mem_dWEN  in  1  EX/MEM register write request
ex_dREN  in  1  ID/EX register holds a load
ex_wsel  in  REGADDR_W  ID/EX destination register
id_rs  in  REGADDR_W  IF/ID source rs
id_rt  in  REGADDR_W  IF/ID source rt
ex_branch_taken  in  1  branch resolved taken in EX
id_jump  in  1  J/JAL/JR decoded in ID
wb_halt  in  1  halt in MEM/WB register
pc_en  out  1  PC update
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes
exmem_clearMemReq  out  1  drop dREN/dWEN in EX/MEM and capture memData
halt  out  1  sticky halt to system

Behaviour:
- Reset: state=RUN; every output 0, including halt.
- FSM states (ctrl_state_t): RUN, MEMDONE, HALTED.
- mem_req = mem_dREN | mem_dWEN.
- RUN: advance = ihit & (!mem_req | dhit).
- RUN, mem_req & dhit & !ihit: all enables 0; exmem_clearMemReq=1 for exactly this cycle; next=MEMDONE.
- RUN, mem_req & !dhit: all enables 0; stay RUN.
- MEMDONE: mem_req is now 0 (cleared); advance = ihit; on ihit next=RUN. dhit is ignored in MEMDONE.
- Advance cycle: all *_en=1 and pc_en=1, then hazard overrides apply.
- Load-use override: applies when ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
  - Sets pc_en=0, ifid_en=0, idex_flush=1 (bubble).
- Branch override: ex_branch_taken sets ifid_flush=1 and idex_flush=1.
- Jump override: id_jump sets ifid_flush=1.
- Override priority: branch > load-use > jump.
  - A branch suppresses load-use and keeps pc_en=1.
  - Load-use suppresses jump; the jump re-evaluates next advance.
- Flushes are asserted only on advance cycles; they are never asserted during a stall.
- exmem_flush and memwb_flush are tied 0 except in HALTED.
- wb_halt=1 in any state: next=HALTED immediately.
  - All enables 0, halt=1 from the following cycle.
  - Pending exmem_clearMemReq for that cycle still issues.
- HALTED: absorbing until nRST. All enables 0, exmem_flush=1, memwb_flush=1, halt=1.
- Outputs are combinational from state plus inputs; only state and halt are registered.
- Reset asserted mid-stall or mid-MEMDONE: asynchronously returns to RUN; no clearMemReq is issued.

Optional Feature:
- Macro: PIPELINE_CONTROLLER_PERF_EN.
- Defined: adds outputs stall_cycles[CNT_W] and flush_count[CNT_W].
  - stall_cycles increments each non-HALTED cycle with pc_en=0.
  - flush_count increments each cycle with ifid_flush|idex_flush.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- ctrl_state_t enum (RUN=2'b00, MEMDONE=2'b01, HALTED=2'b10) goes into cpu_types_pkg; regbits_t is reused for register addresses.
- One sub-module, hazard_unit: combinational load-use detect taking ex_dREN, ex_wsel, id_rs, id_rt and returning lu_stall.
- The FSM and the priority logic stay in pipeline_controller.

Test Plan:
- ihit=1, no mem_req, no hazards, 10 cycles -> pc_en and all *_en=1 every cycle, all flushes 0, halt 0.
- mem_dREN=1, dhit=0 for 3 cycles then dhit=1, ihit=0, then ihit=1 two cycles later -> stalls ×3; one cycle of exmem_clearMemReq=1 with state MEMDONE; advance on the ihit cycle; back to RUN.
- ex_dREN=1, ex_wsel=5'd8, id_rt=5'd8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Repeat with ex_wsel=0 -> no stall.
- ex_branch_taken=1 together with the load-use above, ihit=1 -> ifid_flush=1, idex_flush=1, pc_en=1. Same with ihit=0 -> no flush, all enables 0.
- wb_halt=1 -> next cycle halt=1, all enables 0, exmem_flush and memwb_flush=1, held 20 cycles; nRST pulse -> all outputs 0, state RUN.
- With PIPELINE_CONTROLLER_PERF_EN, 3 stall cycles plus 2 branch flushes -> stall_cycles=3, flush_count=2.
